// File: rtl/mem_access_unit_if.sv
// Request/response and RAM-side signals of the load/store unit.
// master = control FSM + RAM model side, slave = mem_access_unit.
interface mem_access_unit_if #(
    parameter int ADDR_W = 30
);
    logic              start;
    logic              is_store;
    logic [1:0]        size;
    logic              sign_ext;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [31:0]       ram_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [3:0]        ram_byteen;
    logic              ram_wren;
    logic [31:0]       rdata;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, is_store, size, sign_ext, addr, wdata, ram_rdata,
        input  ram_addr, ram_wdata, ram_byteen, ram_wren, rdata, busy, done, err
    );

    modport slave (
        input  start, is_store, size, sign_ext, addr, wdata, ram_rdata,
        output ram_addr, ram_wdata, ram_byteen, ram_wren, rdata, busy, done, err
    );
endinterface

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store unit for the multicycle core; optional MISALIGN_TRAP_EN traps misaligned accesses.
// Store done 2 cycles after start, load done 1+RD_LATENCY cycles; start is ignored (not queued) while busy.
module mem_access_unit #(
    parameter int ADDR_W     = 30,
    parameter int RD_LATENCY = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    mem_access_unit_if.slave bus
);
    localparam int CNT_W = $clog2(RD_LATENCY + 1);
    localparam logic [CNT_W-1:0] WAIT_INIT =
        (RD_LATENCY > 1) ? CNT_W'(RD_LATENCY - 2) : '0;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              store_q;
    logic [1:0]        size_q;
    logic              sext_q;
    logic [1:0]        off_q;
    logic [31:0]       wdata_q;
    logic              mis_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [31:0]       rdata_q;
    logic              mis_req;
    logic              capture;
    logic [3:0]        lane_en;
    logic [31:0]       wdata_rep;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       ld_val;
    logic [3:0]        byteen;
    logic              wren;

`ifdef MISALIGN_TRAP_EN
    // Reserved size 11 behaves as word, hence size[1].
    assign mis_req = ((bus.size == 2'b01) && bus.addr[0]) ||
                     (bus.size[1] && (bus.addr[1:0] != 2'b00));
`else
    assign mis_req = 1'b0;
`endif

    always_comb begin
        lane_en   = 4'b1111;
        wdata_rep = wdata_q;
        case (size_q)
            2'b00: begin
                lane_en   = 4'b0001 << off_q;
                wdata_rep = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                lane_en   = off_q[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata_q[15:0]}};
            end
            default: begin
                lane_en   = 4'b1111;
                wdata_rep = wdata_q;
            end
        endcase
    end

    always_comb begin
        byte_sel = bus.ram_rdata[{off_q, 3'b000} +: 8];
        half_sel = off_q[1] ? bus.ram_rdata[31:16] : bus.ram_rdata[15:0];
        case (size_q)
            2'b00:   ld_val = {{24{sext_q & byte_sel[7]}}, byte_sel};
            2'b01:   ld_val = {{16{sext_q & half_sel[15]}}, half_sel};
            default: ld_val = bus.ram_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_q;
        capture   = 1'b0;
        byteen    = 4'b0000;
        wren      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                // A trapped access never touches the RAM.
                if (!mis_q) begin
                    byteen = lane_en;
                    wren   = store_q;
                end
                if (store_q || mis_q) begin
                    state_nxt = DONE;
                end else if (RD_LATENCY == 1) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt   = WAIT_INIT;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                byteen = lane_en;
                if (cnt_q == '0) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            store_q    <= 1'b0;
            size_q     <= 2'b00;
            sext_q     <= 1'b0;
            off_q      <= 2'b00;
            wdata_q    <= '0;
            mis_q      <= 1'b0;
            ram_addr_q <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
        end else begin
            cnt_q <= cnt_nxt;
            if ((state == IDLE) && bus.start) begin
                store_q    <= bus.is_store;
                size_q     <= bus.size;
                sext_q     <= bus.sign_ext;
                off_q      <= bus.addr[1:0];
                wdata_q    <= bus.wdata;
                mis_q      <= mis_req;
                ram_addr_q <= bus.addr[ADDR_W+1:2];
            end
            if (capture) begin
                rdata_q <= ld_val;
            end
        end
    end

    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_wdata  = wdata_rep;
    assign bus.ram_byteen = byteen;
    assign bus.ram_wren   = wren;
    assign bus.rdata      = rdata_q;
    assign bus.busy       = (state != IDLE);
    assign bus.done       = (state == DONE);
`ifdef MISALIGN_TRAP_EN
    assign bus.err        = (state == DONE) && mis_q;
`else
    assign bus.err        = 1'b0;
`endif
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: one instance with RD_LATENCY=1, one with RD_LATENCY=3.
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mem_access_unit_if #(.ADDR_W(30)) bus1 ();
    mem_access_unit_if #(.ADDR_W(30)) bus3 ();

    mem_access_unit #(.ADDR_W(30), .RD_LATENCY(1)) u_dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
    mem_access_unit #(.ADDR_W(30), .RD_LATENCY(3)) u_dut3 (.clk(clk), .reset_n(reset_n), .bus(bus3));

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int passes = 0;
    int edge_cnt = 0;
    int start_edge = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        edge_cnt++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    function automatic logic get_done(input bit s);
        return s ? bus3.done : bus1.done;
    endfunction

    function automatic logic get_busy(input bit s);
        return s ? bus3.busy : bus1.busy;
    endfunction

    function automatic logic [31:0] get_rdata(input bit s);
        return s ? bus3.rdata : bus1.rdata;
    endfunction

    function automatic logic get_err(input bit s);
        return s ? bus3.err : bus1.err;
    endfunction

    task automatic push(input logic [31:0] r, input logic e, input int l);
        exp_t x;
        x.rdata = r;
        x.err   = e;
        x.lat   = l;
        sb.push_back(x);
    endtask

    task automatic issue(input bit s, input logic st, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd);
        if (s) begin
            bus3.start = 1'b1; bus3.is_store = st; bus3.size = sz;
            bus3.sign_ext = sx; bus3.addr = a; bus3.wdata = wd;
        end else begin
            bus1.start = 1'b1; bus1.is_store = st; bus1.size = sz;
            bus1.sign_ext = sx; bus1.addr = a; bus1.wdata = wd;
        end
        tick();
        start_edge = edge_cnt;
        bus1.start = 1'b0;
        bus3.start = 1'b0;
    endtask

    // Bounded wait for done, then score latency/rdata/err against the queue head.
    task automatic wait_done(input bit s, input string tag);
        exp_t x;
        while (!get_done(s) && (edge_cnt - start_edge) < 30) tick();
        check({tag, "_done"}, 32'(get_done(s)), 32'd1);
        if (sb.size() > 0) begin
            x = sb.pop_front();
            check({tag, "_lat"}, 32'(edge_cnt - start_edge), 32'(x.lat));
            check({tag, "_rdata"}, get_rdata(s), x.rdata);
            check({tag, "_err"}, 32'(get_err(s)), 32'(x.err));
        end
        tick();
        check({tag, "_done_pulse"}, 32'(get_done(s)), 32'd0);
        check({tag, "_idle"}, 32'(get_busy(s)), 32'd0);
    endtask

    int n_wr;
    int n_done;
    logic [31:0] wr_seen[$];

    initial begin
        bus1.start = 0; bus1.is_store = 0; bus1.size = 0; bus1.sign_ext = 0;
        bus1.addr = 0; bus1.wdata = 0; bus1.ram_rdata = 0;
        bus3.start = 0; bus3.is_store = 0; bus3.size = 0; bus3.sign_ext = 0;
        bus3.addr = 0; bus3.wdata = 0; bus3.ram_rdata = 32'hDEAD_BEEF;

        // Reset state
        tick(); tick();
        check("rst_busy", 32'(bus1.busy), 32'd0);
        check("rst_done", 32'(bus1.done), 32'd0);
        check("rst_err", 32'(bus1.err), 32'd0);
        check("rst_rdata", bus1.rdata, 32'd0);
        check("rst_byteen", 32'(bus1.ram_byteen), 32'd0);
        check("rst_wren", 32'(bus1.ram_wren), 32'd0);
        check("rst_addr", 32'(bus1.ram_addr), 32'd0);
        check("rst_busy3", 32'(bus3.busy), 32'd0);
        reset_n = 1'b1;
        tick();

        // Store byte to lane 3
        push(32'd0, 1'b0, 1);
        issue(0, 1'b1, 2'b00, 1'b0, 32'h0000_0103, 32'h0000_00AB);
        check("stb_addr", 32'(bus1.ram_addr), 32'h40);
        check("stb_byteen", 32'(bus1.ram_byteen), 32'b1000);
        check("stb_wdata", bus1.ram_wdata, 32'hABAB_ABAB);
        check("stb_wren", 32'(bus1.ram_wren), 32'd1);
        check("stb_busy", 32'(bus1.busy), 32'd1);
        wait_done(0, "stb");
        check("stb_wren_off", 32'(bus1.ram_wren), 32'd0);
        check("stb_byteen_off", 32'(bus1.ram_byteen), 32'd0);
        check("stb_addr_hold", 32'(bus1.ram_addr), 32'h40);

        // Half loads, signed then unsigned
        bus1.ram_rdata = 32'h8001_1234;
        push(32'hFFFF_8001, 1'b0, 1);
        issue(0, 1'b0, 2'b01, 1'b1, 32'h0000_0202, 32'd0);
        check("ldh_addr", 32'(bus1.ram_addr), 32'h80);
        check("ldh_byteen", 32'(bus1.ram_byteen), 32'b1100);
        check("ldh_wren", 32'(bus1.ram_wren), 32'd0);
        wait_done(0, "ldh_s");
        push(32'h0000_8001, 1'b0, 1);
        issue(0, 1'b0, 2'b01, 1'b0, 32'h0000_0202, 32'd0);
        wait_done(0, "ldh_u");

        // Signed byte from lane 3, word load ignores sign_ext
        push(32'hFFFF_FF80, 1'b0, 1);
        issue(0, 1'b0, 2'b00, 1'b1, 32'h0000_0203, 32'd0);
        wait_done(0, "ldb_s");
        bus1.ram_rdata = 32'hCAFE_F00D;
        push(32'hCAFE_F00D, 1'b0, 1);
        issue(0, 1'b0, 2'b10, 1'b1, 32'h0000_0204, 32'd0);
        check("ldw_addr", 32'(bus1.ram_addr), 32'h81);
        check("ldw_byteen", 32'(bus1.ram_byteen), 32'b1111);
        wait_done(0, "ldw");

        // Half store to upper lanes; rdata must be untouched
        push(32'hCAFE_F00D, 1'b0, 1);
        issue(0, 1'b1, 2'b01, 1'b0, 32'h0000_0002, 32'h1234_ABCD);
        check("sth_wdata", bus1.ram_wdata, 32'hABCD_ABCD);
        check("sth_byteen", 32'(bus1.ram_byteen), 32'b1100);
        wait_done(0, "sth");

        // Misaligned accesses
        bus1.ram_rdata = 32'h8001_1234;
`ifdef MISALIGN_TRAP_EN
        push(32'hCAFE_F00D, 1'b1, 1);
        issue(0, 1'b1, 2'b10, 1'b0, 32'h0000_0101, 32'h5566_7788);
        check("misw_wren", 32'(bus1.ram_wren), 32'd0);
        check("misw_byteen", 32'(bus1.ram_byteen), 32'd0);
        wait_done(0, "misw");
        push(32'hCAFE_F00D, 1'b1, 1);
        issue(0, 1'b0, 2'b01, 1'b1, 32'h0000_0203, 32'd0);
        check("mish_byteen", 32'(bus1.ram_byteen), 32'd0);
        wait_done(0, "mish");
`else
        push(32'hCAFE_F00D, 1'b0, 1);
        issue(0, 1'b1, 2'b10, 1'b0, 32'h0000_0101, 32'h5566_7788);
        check("misw_addr", 32'(bus1.ram_addr), 32'h40);
        check("misw_byteen", 32'(bus1.ram_byteen), 32'b1111);
        check("misw_wdata", bus1.ram_wdata, 32'h5566_7788);
        check("misw_wren", 32'(bus1.ram_wren), 32'd1);
        wait_done(0, "misw");
        push(32'hFFFF_8001, 1'b0, 1);
        issue(0, 1'b0, 2'b01, 1'b1, 32'h0000_0203, 32'd0);
        check("mish_byteen", 32'(bus1.ram_byteen), 32'b1100);
        wait_done(0, "mish");
`endif

        // start held for 6 edges: only samples at N and N+3 execute
        n_wr = 0;
        n_done = 0;
        bus1.is_store = 1'b1; bus1.size = 2'b00; bus1.sign_ext = 1'b0; bus1.addr = 32'd0;
        for (int i = 0; i < 6; i++) begin
            bus1.start = 1'b1;
            bus1.wdata = (i == 0) ? 32'h11 : (i < 3) ? 32'h22 : (i == 3) ? 32'h33 : 32'h44;
            tick();
            if (bus1.ram_wren) begin n_wr++; wr_seen.push_back(bus1.ram_wdata); end
            if (bus1.done) n_done++;
        end
        bus1.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus1.ram_wren) begin n_wr++; wr_seen.push_back(bus1.ram_wdata); end
            if (bus1.done) n_done++;
        end
        check("busy_nwr", 32'(n_wr), 32'd2);
        check("busy_ndone", 32'(n_done), 32'd2);
        if (wr_seen.size() >= 2) begin
            check("busy_wr0", wr_seen[0], 32'h1111_1111);
            check("busy_wr1", wr_seen[1], 32'h3333_3333);
        end

        // Latency-3 unsigned byte load; data valid only in the final wait cycle
        push(32'h0000_0033, 1'b0, 3);
        issue(1, 1'b0, 2'b00, 1'b0, 32'h0000_0001, 32'd0);
        check("l3_addr1", 32'(bus3.ram_addr), 32'h0);
        check("l3_byteen1", 32'(bus3.ram_byteen), 32'b0010);
        tick();
        check("l3_addr2", 32'(bus3.ram_addr), 32'h0);
        check("l3_byteen2", 32'(bus3.ram_byteen), 32'b0010);
        check("l3_nodone2", 32'(bus3.done), 32'd0);
        tick();
        bus3.ram_rdata = 32'h1122_33F4;
        check("l3_addr3", 32'(bus3.ram_addr), 32'h0);
        check("l3_byteen3", 32'(bus3.ram_byteen), 32'b0010);
        check("l3_busy3", 32'(bus3.busy), 32'd1);
        wait_done(1, "l3");
        bus3.ram_rdata = 32'hDEAD_BEEF;
        tick();
        check("l3_hold", bus3.rdata, 32'h0000_0033);

        // Reset while in WAIT
        issue(1, 1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'd0);
        tick();
        check("rw_busy_pre", 32'(bus3.busy), 32'd1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("rw_busy", 32'(bus3.busy), 32'd0);
        check("rw_done", 32'(bus3.done), 32'd0);
        check("rw_rdata", bus3.rdata, 32'd0);
        check("rw_byteen", 32'(bus3.ram_byteen), 32'd0);
        check("rw_rdata1", bus1.rdata, 32'd0);
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus3.done) n_done++;
        end
        check("rw_no_done", 32'(n_done), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store unit for the multicycle core. It sits directly downstream of the control FSM.
- Control pulses `start` in its MEM state. The unit then performs one byte, half or word access to the word-organised data RAM.
- It handles lane selection, byte enables and sign extension, and returns `done` plus the load result to feed the MEM/WB register.

Parameters:
- ADDR_W, 30, word-address width of the RAM port.
- RD_LATENCY, 1, cycles from RAM address valid to `ram_rdata` valid; must be >= 1.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- start  in  1  access request, sampled only in IDLE
- is_store  in  1  1 = store, 0 = load
- size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved (treated as word)
- sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- addr  in  32  byte address
- wdata  in  32  store data, right-justified
- ram_rdata  in  32  RAM read data
- ram_addr  out  ADDR_W  word address, equal to addr[ADDR_W+1:2]
- ram_wdata  out  32  lane-replicated store data
- ram_byteen  out  4  byte enables
- ram_wren  out  1  RAM write strobe
- rdata  out  32  load result
- busy  out  1  state != IDLE
- done  out  1  single-cycle completion pulse
- err  out  1  misalignment pulse, coincident with `done`

Behaviour:
- Reset (clk edge with reset_n = 0):
  - state is forced to IDLE.
  - All outputs go to 0, including `rdata`.
  - An in-flight access is abandoned and no write occurs afterwards.
  - Reset has priority over every other event.
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - If `start`=1, latch is_store, size, sign_ext, addr and wdata, then go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS (1 cycle):
  - Drive ram_addr, ram_byteen and ram_wdata from the latched values.
  - ram_wren = is_store for this cycle only.
  - Store: go to DONE.
  - Load with RD_LATENCY = 1: capture ram_rdata at the end of this cycle and go to DONE.
  - Load with RD_LATENCY > 1: go to WAIT.
- WAIT:
  - Hold ram_addr and ram_byteen stable.
  - Count RD_LATENCY-1 cycles, capture on the last one, then go to DONE.
- DONE (1 cycle): done = 1, then go to IDLE.
- `rdata` holds its value until the next load captures.
- `start` in any state other than IDLE is ignored. It is not queued.
- Timing, with `start` sampled at edge N:
  - Store: ram_wren high in cycle N+1; done in cycle N+2.
  - Load: done in cycle N+1+RD_LATENCY.
- Lanes are little-endian; lane k is bits [8k+7:8k].
- Byte access:
  - ram_byteen = 0001 << addr[1:0].
  - ram_wdata = {4{wdata[7:0]}}.
  - Load uses lane addr[1:0].
- Half access:
  - ram_byteen = 0011 << (2*addr[1]).
  - ram_wdata = {2{wdata[15:0]}}.
  - Load uses bits [16*addr[1]+15 : 16*addr[1]].
- Word access: ram_byteen = 1111, ram_wdata = wdata, load uses the full word.
- Load extension: the selected bits are sign- or zero-extended to 32 bits according to sign_ext. sign_ext is ignored for word loads.
- Outside ACCESS/WAIT, ram_byteen is 0 and ram_wren is 0. ram_addr retains its last value.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Misaligned means a half access with addr[0]=1, or a word access with addr[1:0] != 00.
- With MISALIGN_TRAP_EN defined:
  - A misaligned request goes IDLE -> ACCESS -> DONE.
  - ram_wren and ram_byteen stay 0 throughout.
  - err = 1 together with done.
  - rdata is unchanged.
- Without MISALIGN_TRAP_EN:
  - err is tied to 0.
  - Low address bits are ignored: half uses addr[1] only, word uses lane 0.
  - The access proceeds normally.

Test Plan:
1. Store byte: addr = 0x0000_0103, wdata = 0x0000_00AB.
   - Cycle N+1: ram_addr = 0x40, ram_byteen = 1000, ram_wdata = 0xABAB_ABAB, ram_wren = 1.
   - done in cycle N+2; busy high during N+1..N+2.
2. Signed half load, RD_LATENCY = 1: addr = 0x202, RAM word = 0x8001_1234.
   - rdata = 0xFFFF_8001; done in cycle N+2.
   - Repeat with sign_ext = 0: rdata = 0x0000_8001.
3. Unsigned byte load, RD_LATENCY = 3: addr = 0x001, RAM word = 0x1122_33F4.
   - rdata = 0x0000_0033; done in cycle N+4.
   - ram_addr is stable during N+1..N+3.
4. Misaligned word store at addr = 0x101:
   - With macro: no ram_wren pulse; err = 1 and done = 1 in cycle N+2.
   - Without macro: write to ram_addr = 0x40 with ram_byteen = 1111; err = 0.
5. Busy handling: hold start = 1 continuously for 6 cycles with a store.
   - Exactly two accesses occur: starts are sampled at N and N+3.
   - The request presented during busy/DONE is not executed.
6. Reset mid-access: assert reset_n = 0 during WAIT of a load.
   - Next cycle: state IDLE, busy = 0, done = 0, rdata = 0.
   - No later done pulse appears.
